// File: rtl/pc_fetch_ctrl.sv
// PC sequencer and fetch controller (BOOT/FETCH/HOLD/FLUSH); PC_MISALIGN_TRAP_EN traps misaligned redirects.
// Latency: instruction presented to decode 1 cycle after imem_ack; one BOOT cycle after reset.
// Backpressure: a single held instruction; no new fetch is issued until decode accepts it or a redirect hits.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_taken,
  input  logic        jump,
  input  logic [31:0] target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        misalign_trap
);

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, FLUSH} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] flush_addr, flush_addr_nxt;
  logic [31:0] instr_nxt, instr_pc_nxt;
  logic        instr_valid_nxt, trap_nxt;
  logic        redirect, redir_trap;
  logic [31:0] redir_pc;

  assign redirect = br_taken | jump;

  // Without the trap feature the low target bits are simply dropped.
  assign redir_trap = TRAP_EN & (target[1:0] != 2'b00);
  assign redir_pc   = redir_trap ? TRAP_VEC : (target & 32'hFFFF_FFFC);

  // The abandoned fetch must keep its address on the bus until it is acked.
  assign imem_req  = (state == FETCH) || (state == FLUSH);
  assign imem_addr = (state == FLUSH) ? flush_addr : pc;

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    flush_addr_nxt  = flush_addr;
    instr_nxt       = instr;
    instr_pc_nxt    = instr_pc;
    instr_valid_nxt = instr_valid;
    trap_nxt        = 1'b0;
    case (state)
      BOOT: state_nxt = FETCH;
      FETCH: begin
        if (redirect) begin
          pc_nxt   = redir_pc;
          trap_nxt = redir_trap;
          if (!imem_ack) begin
            flush_addr_nxt = pc;
            state_nxt      = FLUSH;
          end
        end else if (imem_ack) begin
          instr_nxt       = imem_rdata;
          instr_pc_nxt    = pc;
          instr_valid_nxt = 1'b1;
          pc_nxt          = pc + 32'd4;
          state_nxt       = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          instr_valid_nxt = 1'b0;
          pc_nxt          = redir_pc;
          trap_nxt        = redir_trap;
          state_nxt       = FETCH;
        end else if (instr_valid && instr_ready) begin
          instr_valid_nxt = 1'b0;
          state_nxt       = FETCH;
        end
      end
      FLUSH: begin
        if (redirect) begin
          pc_nxt   = redir_pc;
          trap_nxt = redir_trap;
        end
        if (imem_ack) state_nxt = FETCH;
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= BOOT;
      pc            <= RESET_PC;
      flush_addr    <= RESET_PC;
      instr         <= 32'd0;
      instr_pc      <= 32'd0;
      instr_valid   <= 1'b0;
      misalign_trap <= 1'b0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      flush_addr    <= flush_addr_nxt;
      instr         <= instr_nxt;
      instr_pc      <= instr_pc_nxt;
      instr_valid   <= instr_valid_nxt;
      misalign_trap <= trap_nxt;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios, then random traffic against a decode-stream model.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br_taken = 1'b0, jump = 1'b0;
  logic [31:0] target = 32'd0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'd0;
  logic        instr_valid, instr_ready = 1'b0;
  logic [31:0] instr, instr_pc;
  logic        misalign_trap;

  // second instance only exercises the pc wrap-around after reset
  logic        w_req, w_ack, w_valid, w_trap;
  logic [31:0] w_addr, w_instr, w_instr_pc;
  logic        w_zero = 1'b0, w_one = 1'b1;
  logic [31:0] w_tgt = 32'd0, w_data = 32'h13;
  assign w_ack = w_req;

  int nchk = 0, nerr = 0;
  int w_cnt = 0;
  bit w_done = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) u_dut (
    .clk(clk), .rst_n(rst_n), .br_taken(br_taken), .jump(jump), .target(target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .misalign_trap(misalign_trap)
  );

  pc_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC), .TRAP_VEC(TRAP_VEC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .br_taken(w_zero), .jump(w_zero), .target(w_tgt),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_data),
    .instr_valid(w_valid), .instr_ready(w_one), .instr(w_instr), .instr_pc(w_instr_pc),
    .misalign_trap(w_trap)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a >> 2) + 32'd1;
  endfunction

  function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef PC_MISALIGN_TRAP_EN
    return (t[1:0] != 2'b00) ? TRAP_VEC : t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  function automatic bit is_trap(input logic [31:0] t);
`ifdef PC_MISALIGN_TRAP_EN
    return t[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 10 && !imem_req; i++) step();
    if (!imem_req) check("req_timeout", 32'd0, 32'd1);
  endtask

  // request seen, ack one cycle later, instruction presented the cycle after
  task automatic fetch_one(input logic [31:0] ea, input logic [31:0] ed);
    wait_req();
    check("fetch_addr", imem_addr, ea);
    step();
    imem_ack = 1'b1;
    imem_rdata = ed;
    step();
    imem_ack = 1'b0;
    check("fetch_valid", {31'd0, instr_valid}, 32'd1);
    check("fetch_instr", instr, ed);
    check("fetch_pc", instr_pc, ea);
  endtask

  always @(negedge clk) begin
    if (!rst_n) w_cnt = 0;
    else if (w_req && w_ack) begin
      if (w_cnt == 1 && !w_done) begin
        check("wrap_addr", w_addr, 32'h0000_0000);
        w_done = 1;
      end
      w_cnt++;
    end
  end

  logic [31:0] exp_pc, stale_addr, tgt;
  bit          exp_trap, stale, in_boot, prev_rst, redir;

  initial begin
    // reset and the basic fetch sequence
    instr_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    check("boot_req", {31'd0, imem_req}, 32'd0);
    check("boot_valid", {31'd0, instr_valid}, 32'd0);
    check("boot_addr", imem_addr, RESET_PC);
    check("boot_instr", instr, 32'd0);
    fetch_one(32'h0, 32'h1);
    fetch_one(32'h4, 32'h2);
    fetch_one(32'h8, 32'h3);

    // decode stall in HOLD
    step();
    instr_ready = 1'b0;
    fetch_one(32'hC, 32'h4);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_instr", instr, 32'h4);
      check("stall_pc", instr_pc, 32'hC);
      check("stall_req", {31'd0, imem_req}, 32'd0);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
    end
    instr_ready = 1'b1;
    step();
    check("after_stall_req", {31'd0, imem_req}, 32'd1);
    check("after_stall_addr", imem_addr, 32'h10);

    // branch while the fetch is outstanding; stale DEAD must be dropped
    br_taken = 1'b1;
    target = 32'h40;
    step();
    br_taken = 1'b0;
    check("flush_req", {31'd0, imem_req}, 32'd1);
    check("flush_addr", imem_addr, 32'h10);
    for (int i = 0; i < 2; i++) begin
      step();
      check("flush_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD;
    step();
    imem_ack = 1'b0;
    check("post_flush_valid", {31'd0, instr_valid}, 32'd0);
    check("post_flush_addr", imem_addr, 32'h40);
    fetch_one(32'h40, 32'h11);

    // misaligned jump taken from HOLD with decode ready
    jump = 1'b1;
    target = 32'h42;
    step();
    jump = 1'b0;
    check("mis_valid", {31'd0, instr_valid}, 32'd0);
    check("mis_trap", {31'd0, misalign_trap}, {31'd0, is_trap(32'h42)});
    check("mis_addr", imem_addr, eff_target(32'h42));
    step();
    check("mis_trap_pulse", {31'd0, misalign_trap}, 32'd0);

    // reset during FLUSH, with an ack arriving under reset
    br_taken = 1'b1;
    target = 32'h80;
    step();
    br_taken = 1'b0;
    rst_n = 1'b0;
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    rst_n = 1'b1;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_trap", {31'd0, misalign_trap}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_addr", imem_addr, RESET_PC);
    step();
    check("rst_first_req", {31'd0, imem_req}, 32'd1);
    fetch_one(RESET_PC, mem(RESET_PC));

    // random traffic against the decode-stream model
    rst_n = 1'b0;
    step();
    prev_rst = 1'b0;
    exp_pc = RESET_PC;
    exp_trap = 1'b0;
    stale = 1'b0;
    stale_addr = 32'd0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      in_boot = !prev_rst;
      check("r_trap", {31'd0, misalign_trap}, {31'd0, exp_trap});
      check("r_req_and_valid", {31'd0, imem_req & instr_valid}, 32'd0);
      if (in_boot) begin
        check("r_boot_req", {31'd0, imem_req}, 32'd0);
        check("r_boot_addr", imem_addr, RESET_PC);
      end
      if (instr_valid) begin
        check("r_instr_pc", instr_pc, exp_pc);
        check("r_instr", instr, mem(exp_pc));
      end
      if (imem_req) check("r_addr", imem_addr, stale ? stale_addr : exp_pc);

      rst_n = ($urandom_range(0, 199) != 0);
      if (imem_req) begin
        imem_ack = ($urandom_range(0, 1) == 1);
        imem_rdata = mem(imem_addr);
      end else begin
        imem_ack = ($urandom_range(0, 7) == 0);
        imem_rdata = 32'hBAD0_0000 ^ $urandom_range(0, 65535);
      end
      instr_ready = ($urandom_range(0, 1) == 1);
      redir = ($urandom_range(0, 9) == 0);
      br_taken = redir && ($urandom_range(0, 1) == 1);
      jump = redir && !br_taken;
      tgt = $urandom_range(0, 1023);
      if ($urandom_range(0, 15) == 0) tgt = tgt | 32'hFFFF_FC00;
      if ($urandom_range(0, 3) != 0) tgt = tgt & 32'hFFFF_FFFC;
      target = tgt;

      exp_trap = 1'b0;
      if (!rst_n) begin
        exp_pc = RESET_PC;
        stale = 1'b0;
      end else if (!in_boot) begin
        if (imem_req && imem_ack) stale = 1'b0;
        if (redir) begin
          if (imem_req && !imem_ack) begin
            stale = 1'b1;
            stale_addr = imem_addr;
          end
          exp_pc = eff_target(tgt);
          exp_trap = is_trap(tgt);
        end else if (instr_valid && instr_ready) begin
          exp_pc = exp_pc + 32'd4;
        end
      end
      prev_rst = rst_n;
      step();
    end

    if (!w_done) check("wrap_seen", {31'd0, w_done}, 32'd1);
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
